// File: rtl/whack_a_mole_multi.sv
// whack_a_mole_multi: N-hole whack-a-mole game core.
// One lit mole at a time picked from a 16-bit Galois LFSR, a per-mole timeout
// window, wrong-button penalties, a saturating score, lives and an end screen.
// Optional feature macro: WAM_SPEEDUP_EN (difficulty level that halves the
// mole window on every 8th hit, up to level 3).
module whack_a_mole_multi #(
    parameter int N_HOLES     = 4,
    parameter int SCORE_W     = 7,
    parameter int LIVES_W     = 2,
    parameter int LIVES_INIT  = 3,
    parameter int MOLE_WINDOW = 1000,
    parameter int GAP_CYCLES  = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_HOLES-1:0] buttons,
    output logic [N_HOLES-1:0] moles,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state,
    output logic [1:0]         level
);

    localparam int IDX_W = $clog2(N_HOLES);
    localparam int WIN_W = $clog2(MOLE_WINDOW);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [15:0]        LFSR_TAPS = 16'hB400;
    localparam logic [15:0]        LFSR_SEED = 16'hACE1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [GAP_W-1:0]   GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SPAWN     = 3'd1,
        ACTIVE    = 3'd2,
        HIT       = 3'd3,
        MISS      = 3'd4,
        ENDSCREEN = 3'd5
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [N_HOLES-1:0] r_btn_q;
    logic [15:0]        r_lfsr;
    logic [15:0]        w_lfsr_nxt;
    logic [IDX_W-1:0]   r_idx,     w_idx_nxt;
    logic [WIN_W-1:0]   r_win_cnt, w_win_cnt_nxt;
    logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [SCORE_W-1:0] r_score,   w_score_nxt;
    logic [LIVES_W-1:0] r_lives,   w_lives_nxt;

    logic [N_HOLES-1:0] w_press;
    logic [N_HOLES-1:0] w_lit;
    logic               w_any_press;
    logic               w_wrong;
    logic               w_right;
    logic [IDX_W-1:0]   w_raw_idx;
    logic [IDX_W-1:0]   w_spawn_idx;
    logic [WIN_W-1:0]   w_win_load;
    logic [SCORE_W-1:0] w_score_inc;

`ifdef WAM_SPEEDUP_EN
    logic [1:0]         r_level,   w_level_nxt;
`endif

    // Rising-edge detect: a held button produces exactly one press.
    assign w_press     = buttons & ~r_btn_q;
    assign w_any_press = |w_press;
    assign w_lit       = N_HOLES'(1) << r_idx;
    // Any press off the lit hole is a miss, even alongside the correct one.
    assign w_wrong     = |(w_press & ~w_lit);
    assign w_right     = |(w_press & w_lit);

    // Galois step; the seed is nonzero so the sequence never reaches zero.
    assign w_lfsr_nxt  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    // Never light the same hole twice in a row.
    assign w_raw_idx   = IDX_W'(r_lfsr % 16'(N_HOLES));
    assign w_spawn_idx = (w_raw_idx != r_idx)              ? w_raw_idx :
                         (w_raw_idx == IDX_W'(N_HOLES - 1)) ? '0 : w_raw_idx + 1'b1;

    assign w_score_inc = (r_score == SCORE_MAX) ? r_score : r_score + 1'b1;

`ifdef WAM_SPEEDUP_EN
    assign w_win_load  = WIN_W'((MOLE_WINDOW >> r_level) - 1);
    assign level       = r_level;
`else
    assign w_win_load  = WIN_W'(MOLE_WINDOW - 1);
    assign level       = 2'd0;
`endif

    assign state = r_state;
    assign score = r_score;
    assign lives = r_lives;

    // Next-state and next-datapath logic for the game FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_win_cnt_nxt = r_win_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_score_nxt   = r_score;
        w_lives_nxt   = r_lives;
`ifdef WAM_SPEEDUP_EN
        w_level_nxt   = r_level;
`endif
        case (r_state)
            IDLE: begin
                if (w_any_press) begin
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES_W'(LIVES_INIT);
`ifdef WAM_SPEEDUP_EN
                    w_level_nxt = 2'd0;
`endif
                    w_state_nxt = SPAWN;
                end
            end
            SPAWN: begin
                w_idx_nxt     = w_spawn_idx;
                w_win_cnt_nxt = w_win_load;
                w_state_nxt   = ACTIVE;
            end
            ACTIVE: begin
                if (w_wrong || (!w_right && r_win_cnt == '0)) begin
                    w_gap_cnt_nxt = GAP_LOAD;
                    if (r_lives <= LIVES_W'(1)) begin
                        w_lives_nxt = '0;
                        w_state_nxt = ENDSCREEN;
                    end else begin
                        w_lives_nxt = r_lives - 1'b1;
                        w_state_nxt = MISS;
                    end
                end else if (w_right) begin
                    w_score_nxt   = w_score_inc;
                    w_gap_cnt_nxt = GAP_LOAD;
                    w_state_nxt   = HIT;
`ifdef WAM_SPEEDUP_EN
                    if ((int'(w_score_inc) % 8 == 0) && (r_level != 2'd3))
                        w_level_nxt = r_level + 1'b1;
`endif
                end else begin
                    w_win_cnt_nxt = r_win_cnt - 1'b1;
                end
            end
            HIT, MISS: begin
                if (r_gap_cnt == '0) w_state_nxt = SPAWN;
                else                 w_gap_cnt_nxt = r_gap_cnt - 1'b1;
            end
            ENDSCREEN: begin
                if (w_any_press) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Mole LEDs decoded from the registered state and stored hole.
    always_comb begin
        moles = '0;
        if (r_state == ACTIVE)         moles = w_lit;
        else if (r_state == ENDSCREEN) moles = '1;
    end

    // State and datapath registers; reset returns the core to a fresh IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_btn_q   <= '0;
            r_lfsr    <= LFSR_SEED;
            r_idx     <= '0;
            r_win_cnt <= '0;
            r_gap_cnt <= '0;
            r_score   <= '0;
            r_lives   <= LIVES_W'(LIVES_INIT);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state   <= w_state_nxt;
            r_btn_q   <= buttons;
            r_lfsr    <= w_lfsr_nxt;
            r_idx     <= w_idx_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_score   <= w_score_nxt;
            r_lives   <= w_lives_nxt;
        end
    end

`ifdef WAM_SPEEDUP_EN
    // Difficulty level register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_level <= 2'd0;
        else       r_level <= w_level_nxt;
    end
`endif

endmodule

// File: tb/tb_whack_a_mole_multi.sv
// tb_whack_a_mole_multi: scenario bench for whack_a_mole_multi.
// Expected holes come from an LFSR model advanced every clock; expected score,
// lives, level and window lengths come from the game rules.
// Define WAM_SPEEDUP_EN together with the RTL to exercise the difficulty ramp.
module tb_whack_a_mole_multi;

    localparam int N_HOLES    = 4;
    localparam int SCORE_W    = 7;
    localparam int LIVES_W    = 2;
    localparam int LIVES_INIT = 3;
    localparam int GAP_CYCLES = 2;
`ifdef WAM_SPEEDUP_EN
    localparam int MOLE_WINDOW = 16;
`else
    localparam int MOLE_WINDOW = 10;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [N_HOLES-1:0] buttons;
    logic [N_HOLES-1:0] moles;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic [2:0]         state;
    logic [1:0]         level;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    int          m_prev;
    int          cur_idx;
    int          exp_score;
    int          exp_lives;

    whack_a_mole_multi #(
        .N_HOLES    (N_HOLES),
        .SCORE_W    (SCORE_W),
        .LIVES_W    (LIVES_W),
        .LIVES_INIT (LIVES_INIT),
        .MOLE_WINDOW(MOLE_WINDOW),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .buttons(buttons),
        .moles  (moles),
        .score  (score),
        .lives  (lives),
        .state  (state),
        .level  (level)
    );

    always #5 clk = ~clk;

    // Reference LFSR: reseeded by reset, one Galois step per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr = 16'hACE1;
        else       m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    function automatic int exp_level();
`ifdef WAM_SPEEDUP_EN
        return (exp_score / 8 > 3) ? 3 : exp_score / 8;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_win();
        return MOLE_WINDOW >> exp_level();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hole the game must pick during the current SPAWN cycle.
    task automatic next_hole(output int idx);
        idx = int'(m_lfsr) % N_HOLES;
        if (idx == m_prev) idx = (idx + 1) % N_HOLES;
        m_prev = idx;
    endtask

    task automatic wait_spawn(input string tag);
        int c = 0;
        while (state != 3'd1 && c < 50) begin
            tick();
            c++;
        end
        n_cmp++;
        if (state !== 3'd1) begin n_bad++; $display("FAIL %s_wait_spawn: state=%0d want 1", tag, state); end
    endtask

    task automatic spawn_to_active(input string tag);
        logic [N_HOLES-1:0] exp_m;
        next_hole(cur_idx);
        exp_m = N_HOLES'(1) << cur_idx;
        tick();
        n_cmp++;
        if (state !== 3'd2 || moles !== exp_m) begin
            n_bad++;
            $display("FAIL %s_active: state=%0d moles=%b want 2 %b", tag, state, moles, exp_m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; buttons = '0; m_prev = 0; exp_score = 0; exp_lives = LIVES_INIT;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (moles !== 4'b0000) begin n_bad++; $display("FAIL reset_moles: got %b want 0000", moles); end
        n_cmp++; if (score !== 7'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL reset_lives: got %0d want 3", lives); end
        n_cmp++; if (level !== 2'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    endtask

    task automatic test_start();
        buttons = 4'b0001; tick(); buttons = '0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL start_spawn: state=%0d want 1", state); end
        n_cmp++; if (score !== 7'd0 || lives !== 2'd3) begin n_bad++; $display("FAIL start_regs: score=%0d lives=%0d want 0 3", score, lives); end
        spawn_to_active("start");
    endtask

    task automatic test_hit();
        int prev;
        repeat (3) tick();
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL hit_idle_active: state=%0d want 2", state); end
        buttons = N_HOLES'(1) << cur_idx; tick(); buttons = '0;
        exp_score = 1;
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL hit_state: got %0d want 3", state); end
        n_cmp++; if (score !== 7'(exp_score)) begin n_bad++; $display("FAIL hit_score: got %0d want %0d", score, exp_score); end
        n_cmp++; if (moles !== 4'b0000) begin n_bad++; $display("FAIL hit_moles: got %b want 0000", moles); end
        tick();
        n_cmp++; if (state !== 3'd3 || moles !== 4'b0000) begin n_bad++; $display("FAIL hit_gap2: state=%0d moles=%b want 3 0000", state, moles); end
        tick();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL hit_respawn: state=%0d want 1", state); end
        prev = cur_idx;
        spawn_to_active("hit_next");
        n_cmp++; if (moles === (N_HOLES'(1) << prev)) begin n_bad++; $display("FAIL hit_new_hole: moles=%b repeats previous hole %0d", moles, prev); end
    endtask

    task automatic test_timeout();
        for (int m = 0; m < 3; m++) begin
            int lit = 0;
            for (int c = 0; c < 40 && state == 3'd2; c++) begin
                lit++;
                tick();
            end
            exp_lives--;
            n_cmp++; if (lit != exp_win()) begin n_bad++; $display("FAIL timeout_len%0d: lit %0d cycles want %0d", m, lit, exp_win()); end
            n_cmp++; if (lives !== 2'(exp_lives)) begin n_bad++; $display("FAIL timeout_lives%0d: got %0d want %0d", m, lives, exp_lives); end
            n_cmp++; if (score !== 7'(exp_score)) begin n_bad++; $display("FAIL timeout_score%0d: got %0d want %0d", m, score, exp_score); end
            if (m < 2) begin
                n_cmp++; if (state !== 3'd4 || moles !== 4'b0000) begin n_bad++; $display("FAIL timeout_miss%0d: state=%0d moles=%b want 4 0000", m, state, moles); end
                tick(); tick();
                n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL timeout_respawn%0d: state=%0d want 1", m, state); end
                spawn_to_active("timeout");
            end else begin
                n_cmp++; if (state !== 3'd5 || moles !== 4'b1111) begin n_bad++; $display("FAIL end_screen: state=%0d moles=%b want 5 1111", state, moles); end
            end
        end
        tick();
        n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL end_hold: state=%0d want 5", state); end
        buttons = 4'b0100; tick(); buttons = '0;
        n_cmp++; if (state !== 3'd0 || moles !== 4'b0000) begin n_bad++; $display("FAIL end_to_idle: state=%0d moles=%b want 0 0000", state, moles); end
        n_cmp++; if (score !== 7'(exp_score) || lives !== 2'd0) begin n_bad++; $display("FAIL idle_hold: score=%0d lives=%0d want %0d 0", score, lives, exp_score); end
    endtask

    task automatic test_simultaneous();
        buttons = 4'b0010; tick(); buttons = '0;
        exp_score = 0; exp_lives = LIVES_INIT;
        n_cmp++; if (state !== 3'd1 || score !== 7'd0 || lives !== 2'd3) begin n_bad++; $display("FAIL restart: state=%0d score=%0d lives=%0d want 1 0 3", state, score, lives); end
        spawn_to_active("simul");
        buttons = (N_HOLES'(1) << cur_idx) | (N_HOLES'(1) << ((cur_idx + 1) % N_HOLES));
        tick(); buttons = '0;
        exp_lives--;
        n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL simul_state: got %0d want 4", state); end
        n_cmp++; if (lives !== 2'(exp_lives) || score !== 7'(exp_score)) begin n_bad++; $display("FAIL simul_regs: lives=%0d score=%0d want %0d %0d", lives, score, exp_lives, exp_score); end
        tick(); tick();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL simul_respawn: state=%0d want 1", state); end
        // Hold the upcoming hole's button across the SPAWN->ACTIVE edge.
        next_hole(cur_idx);
        buttons = N_HOLES'(1) << cur_idx;
        tick();
        n_cmp++; if (state !== 3'd2 || moles !== (N_HOLES'(1) << cur_idx)) begin n_bad++; $display("FAIL held_active: state=%0d moles=%b", state, moles); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL held_no_hit%0d: state=%0d want 2", c, state); end
        end
        buttons = '0; tick();
        buttons = N_HOLES'(1) << cur_idx; tick(); buttons = '0;
        exp_score++;
        n_cmp++; if (state !== 3'd3 || score !== 7'(exp_score)) begin n_bad++; $display("FAIL repress_hit: state=%0d score=%0d want 3 %0d", state, score, exp_score); end
    endtask

    task automatic test_press_at_timeout();
        wait_spawn("edge");
        spawn_to_active("edge");
        repeat (exp_win() - 1) tick();
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL edge_last_cycle: state=%0d want 2", state); end
        buttons = N_HOLES'(1) << cur_idx; tick(); buttons = '0;
        exp_score++;
        n_cmp++; if (state !== 3'd3 || score !== 7'(exp_score)) begin n_bad++; $display("FAIL edge_press_wins: state=%0d score=%0d want 3 %0d", state, score, exp_score); end
    endtask

    task automatic test_reset_mid();
        while (exp_score < 5) begin
            wait_spawn("pre_rst");
            spawn_to_active("pre_rst");
            buttons = N_HOLES'(1) << cur_idx; tick(); buttons = '0;
            exp_score++;
            n_cmp++; if (score !== 7'(exp_score)) begin n_bad++; $display("FAIL pre_rst_score: got %0d want %0d", score, exp_score); end
        end
        wait_spawn("mid_rst");
        spawn_to_active("mid_rst");
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (state !== 3'd0 || moles !== 4'b0000) begin n_bad++; $display("FAIL async_rst: state=%0d moles=%b want 0 0000", state, moles); end
        n_cmp++; if (score !== 7'd0 || lives !== 2'd3 || level !== 2'd0) begin n_bad++; $display("FAIL async_rst_regs: score=%0d lives=%0d level=%0d want 0 3 0", score, lives, level); end
        m_prev = 0; exp_score = 0; exp_lives = LIVES_INIT;
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL post_rst_idle: state=%0d want 0", state); end
        buttons = 4'b1000; tick(); buttons = '0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL post_rst_spawn: state=%0d want 1", state); end
        spawn_to_active("post_rst");
    endtask

    task automatic test_saturation();
        for (int h = 0; h < 130; h++) begin
            buttons = N_HOLES'(1) << cur_idx; tick(); buttons = '0;
            if (exp_score < 127) exp_score++;
            n_cmp++; if (state !== 3'd3 || score !== 7'(exp_score)) begin n_bad++; $display("FAIL sat_hit%0d: state=%0d score=%0d want 3 %0d", h, state, score, exp_score); end
            n_cmp++; if (level !== 2'(exp_level())) begin n_bad++; $display("FAIL sat_level%0d: got %0d want %0d", h, level, exp_level()); end
`ifdef WAM_SPEEDUP_EN
            if (exp_score == 8) begin
                int lit = 0;
                wait_spawn("speed");
                spawn_to_active("speed");
                for (int c = 0; c < 40 && state == 3'd2; c++) begin
                    lit++;
                    tick();
                end
                exp_lives--;
                n_cmp++; if (lit != exp_win()) begin n_bad++; $display("FAIL speed_window: lit %0d cycles want %0d", lit, exp_win()); end
                n_cmp++; if (state !== 3'd4 || lives !== 2'(exp_lives)) begin n_bad++; $display("FAIL speed_miss: state=%0d lives=%0d want 4 %0d", state, lives, exp_lives); end
            end
`endif
            wait_spawn("sat");
            spawn_to_active("sat");
        end
        n_cmp++; if (score !== 7'd127) begin n_bad++; $display("FAIL sat_final: score=%0d want 127", score); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_timeout();
        test_simultaneous();
        test_press_at_timeout();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/whack_a_mole_multi.md
# whack_a_mole_multi

Parametrised whack-a-mole game core: N_HOLES mole outputs, N_HOLES button inputs, an LFSR-driven spawn sequence, saturating score, lives and an end screen. It sits between the board's debounced push-buttons and the LED and seven-segment drivers and is the N-hole successor of the 4-hole advanced game. It adds a per-mole timeout window, wrong-button penalties and an optional difficulty ramp.

## Interface
- N_HOLES, 4: number of holes/buttons, 2..16
- SCORE_W, 7: score width
- LIVES_W, 2: lives width
- LIVES_INIT, 3: lives loaded at game start, 1..2^LIVES_W-1
- MOLE_WINDOW, 1000: cycles a mole stays up, at least 8
- GAP_CYCLES, 200: cycles in HIT/MISS before the next spawn, at least 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- buttons  in  N_HOLES  debounced, active-high levels; bit i is hole i
- moles  out  N_HOLES  one-hot lit mole in ACTIVE; all ones in ENDSCREEN; zero otherwise
- score  out  SCORE_W  hits this game
- lives  out  LIVES_W  remaining lives
- state  out  3  FSM state: IDLE=0, SPAWN=1, ACTIVE=2, HIT=3, MISS=4, ENDSCREEN=5
- level  out  2  difficulty level; always 0 without WAM_SPEEDUP_EN

## Operation
- Edge detect: btn_q is buttons registered. press = buttons & ~btn_q. The FSM acts on press at the same clock edge it is sampled. Held buttons never re-trigger.
- LFSR: 16-bit Galois, taps 0xB400, seed 0xACE1 on reset. It advances every cycle in every state and never reaches zero.
- IDLE: moles=0; score and lives hold their last values. Any press: score=0, lives=LIVES_INIT, level=0, go to SPAWN.
- SPAWN (1 cycle):
  - idx = lfsr mod N_HOLES; if idx equals the previous hole, idx = (idx+1) mod N_HOLES.
  - Store idx, load window counter with win-1, go to ACTIVE.
- ACTIVE: moles = 1<<idx. Exit conditions, in priority order:
  - press on any bit other than idx: MISS, even if bit idx is also pressed.
  - press on bit idx only: HIT.
  - counter==0 with no press: MISS (timeout).
  - Otherwise the counter decrements.
- HIT: on entry, score += 1, saturating at 2^SCORE_W-1. moles=0. Stays GAP_CYCLES cycles, then SPAWN. Presses are ignored.
- MISS: on entry, lives -= 1.
  - If lives was 1: go to ENDSCREEN, lives=0.
  - Else: moles=0, stay GAP_CYCLES cycles, then SPAWN. Presses are ignored.
- ENDSCREEN: moles all ones; score and lives held. Any press: go to IDLE.
- Widths: the window counter is $clog2(MOLE_WINDOW) bits. Score never wraps. Lives never underflow.

## Timing
- Reset values: state=IDLE, moles=0, score=0, lives=LIVES_INIT, level=0, btn_q=0, LFSR=0xACE1, counters=0.
- Reset acts immediately and asynchronously in any state, including mid-ACTIVE. There is no pending hit or miss after release.
- Press-to-response: a press sampled at edge k changes state, score and lives at edge k. Outputs are registered and visible after edge k.
- A mole is lit for exactly win cycles when not pressed. MISS is entered at the edge ending the win-th ACTIVE cycle.
- HIT and MISS each last exactly GAP_CYCLES cycles. SPAWN lasts 1 cycle.
- Simultaneous correct and wrong press in the same cycle: MISS.
- Press on the same edge the counter hits 0: the press wins.
- A button already held when ACTIVE is entered does not count until it is released and pressed again.

## Configuration
- WAM_SPEEDUP_EN defined:
  - level increments, saturating at 3, on every 8th hit (score mod 8 == 0 after increment).
  - win = MOLE_WINDOW >> level, latched at SPAWN.
- WAM_SPEEDUP_EN undefined:
  - level tied to 0; win = MOLE_WINDOW always.
  - No level logic is synthesised.

## Test plan
Bench parameters: N_HOLES=4, MOLE_WINDOW=10, GAP_CYCLES=2, LIVES_INIT=3. Hole choice comes from an LFSR reference model.
- Reset, then pulse buttons[0] in IDLE: state goes 0->1->2; score=0, lives=3; moles is one-hot on the model's idx.
- In ACTIVE, press the lit bit: state=3 at the same edge, score=1, moles=0 for 2 cycles, then state=1. The next idx differs from the previous one.
- Let three moles time out: each stays lit exactly 10 cycles. lives goes 2, 1, 0; the third miss goes to state=5 with moles=4'b1111 and score held. A press returns state=0.
- Press the lit bit and a wrong bit in the same cycle: state=4, lives decrements, score unchanged. Holding a button into ACTIVE produces no hit.
- Assert reset for 1 cycle mid-ACTIVE with score=5: all outputs return to reset values immediately; LFSR=0xACE1.
- With WAM_SPEEDUP_EN and MOLE_WINDOW=16: after 8 hits level=1 and the mole stays lit 8 cycles. score saturates at 127 with SCORE_W=7.
